// File: rtl/ped_request_conditioner_if.sv
// Handshake bundle between the pedestrian button front-end, the request
// conditioner and the traffic-light controller.
interface ped_request_conditioner_if;
    logic       Boton;
    logic       Pasar_Persona;
    logic       IN;
    logic [1:0] Estado_Salida;
    logic [7:0] Peticiones;

    modport master (
        output Boton,
        output Pasar_Persona,
        input  IN,
        input  Estado_Salida,
        input  Peticiones
    );

    modport slave (
        input  Boton,
        input  Pasar_Persona,
        output IN,
        output Estado_Salida,
        output Peticiones
    );
endinterface

// File: rtl/ped_request_conditioner.sv
// Synchronizes and debounces the crosswalk button, latches presses into a
// level request for the light FSM, and spaces pedestrian phases with a cooldown.
module ped_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    ped_request_conditioner_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_SERVING  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_db;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_press;
    state_t           r_state;
    logic             r_queued;
    logic [CNT_W-1:0] r_cd_cnt;
    logic             r_in;
    logic [7:0]       r_peticiones;

    state_t           w_next_state;
    logic             w_next_queued;
    logic [CNT_W-1:0] w_next_cd;
    logic             w_pet_inc;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.Boton;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: any return to the accepted level restarts the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_btn_db <= 1'b0;
            r_db_cnt <= CNT_ZERO;
            r_press  <= 1'b0;
        end else if (r_sync2 == r_btn_db) begin
            r_db_cnt <= CNT_ZERO;
            r_press  <= 1'b0;
        end else if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_sync2;
            r_db_cnt <= CNT_ZERO;
            r_press  <= r_sync2;
        end else begin
            r_db_cnt <= r_db_cnt + CNT_ONE;
            r_press  <= 1'b0;
        end
    end

    // Next-state, queued-press and cooldown-counter logic.
    always_comb begin
        w_next_state  = r_state;
        w_next_queued = r_queued;
        w_next_cd     = r_cd_cnt;
        w_pet_inc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_press) begin
                    w_next_state = ST_PENDING;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (bus.Pasar_Persona) begin
                    w_next_state = ST_SERVING;
                    w_pet_inc    = 1'b1;
                end else begin
                    w_next_state = ST_PENDING;
                end
            end
            ST_SERVING: begin
                if (r_press) begin
                    w_next_queued = 1'b1;
                end else begin
                    w_next_queued = r_queued;
                end
                if (!bus.Pasar_Persona) begin
                    w_next_state = ST_COOLDOWN;
                    w_next_cd    = CD_LAST;
                end else begin
                    w_next_state = ST_SERVING;
                end
            end
            ST_COOLDOWN: begin
                // A press landing on the expiry cycle still counts as queued.
                if (r_cd_cnt == CNT_ZERO) begin
                    w_next_queued = 1'b0;
                    if (r_queued || r_press) begin
                        w_next_state = ST_PENDING;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_cd = r_cd_cnt - CNT_ONE;
                    if (r_press) begin
                        w_next_queued = 1'b1;
                    end else begin
                        w_next_queued = r_queued;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, queue, cooldown and served-count registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_queued     <= 1'b0;
            r_cd_cnt     <= CNT_ZERO;
            r_in         <= 1'b0;
            r_peticiones <= 8'd0;
        end else begin
            r_state  <= w_next_state;
            r_queued <= w_next_queued;
            r_cd_cnt <= w_next_cd;
            r_in     <= (w_next_state == ST_PENDING);
            if (w_pet_inc && (r_peticiones != 8'd255)) begin
                r_peticiones <= r_peticiones + 8'd1;
            end else begin
                r_peticiones <= r_peticiones;
            end
        end
    end

    assign bus.IN            = r_in;
    assign bus.Estado_Salida = r_state;
    assign bus.Peticiones    = r_peticiones;

endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
Upstream stage of the pedestrian traffic-light FSM. It synchronizes and debounces the raw crosswalk button and latches a press into a level request `IN` that drives the light controller. The request is held until the controller acknowledges with its one-cycle `Pasar_Persona` pulse. After service, a cooldown window enforces minimum spacing between pedestrian phases, and a press made during service or cooldown is queued rather than lost.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized button must hold a new level before it is accepted (>=1)
COOLDOWN_CYCLES, 8, cycles spent in COOLDOWN after service (>=1)
CNT_W, 4, width of the debounce and cooldown counters; must hold max(DEBOUNCE_CYCLES, COOLDOWN_CYCLES)-1

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high reset
Boton  input  1  raw pedestrian button, asynchronous to Clk, 1 = pressed
Pasar_Persona  input  1  service acknowledge from the light FSM, high while pedestrians cross
IN  output  1  registered request to the light FSM, 1 = crossing pending
Estado_Salida  output  2  current state, for the TB: 0=IDLE 1=PENDING 2=SERVING 3=COOLDOWN
Peticiones  output  8  count of served requests, saturates at 255

Behaviour:
- Reset (async, active-high) clears everything immediately: sync flops, btn_db, debounce counter, press pulse, queued flag, cooldown counter, state=IDLE, IN=0, Peticiones=0.
- Synchronizer: two flops on Boton. Output s lags Boton by 2 edges.
- Debounce (btn_db is a register, reset value 0):
  - If s==btn_db: counter<=0.
  - Else, if counter==DEBOUNCE_CYCLES-1: btn_db<=s, counter<=0.
  - Else: counter++.
  - Any bounce resets the count.
- Press event: registered 1-cycle pulse press, set on the same edge btn_db goes 0->1. A release generates nothing.
- FSM is Moore. IN=1 iff state==PENDING; IN is driven directly from the state register, with no combinational path from inputs.
  - IDLE: press -> PENDING. Pasar_Persona is ignored.
  - PENDING: Pasar_Persona==1 -> SERVING and Peticiones++ (saturating). Further presses are ignored because a request is already pending.
  - SERVING: stays while Pasar_Persona==1. Pasar_Persona==0 -> COOLDOWN with cooldown counter loaded to COOLDOWN_CYCLES-1. A press here sets queued.
  - COOLDOWN: counter decrements each cycle. A press sets queued. At counter==0: go to PENDING if queued (or a press arrives this same cycle), else IDLE; queued is cleared either way. Pasar_Persona is ignored.
  - Unused encodings: none; the 2-bit state is fully used.
- Timing:
  - Residency: exactly COOLDOWN_CYCLES cycles in COOLDOWN.
  - Latency from a clean Boton rise (before edge 1) to IN=1: after edge 3+DEBOUNCE_CYCLES (7 with defaults).
  - IN falls on the edge that samples Pasar_Persona=1, so the light FSM never sees IN=1 again when it returns from its all-red phase unless a new request exists.
- Simultaneous events:
  - press and Pasar_Persona in the same cycle while PENDING -> SERVING, press dropped.
  - press and cooldown expiry in the same cycle -> PENDING.
- Button held through Reset: btn_db restarts at 0, so a still-held button produces a new press DEBOUNCE_CYCLES+2 cycles after Reset release. This is intended.

Test Plan:
- Reset asserted mid-PENDING (async, between edges) -> IN=0 and Estado_Salida=0 immediately, before the next edge; Peticiones=0.
- Clean press: Boton 0->1 held 20 cycles (defaults) -> IN rises after edge 7. Pasar_Persona pulses high for 1 cycle at edge 10 -> IN=0 at edge 10. Peticiones=1. Estado_Salida shows 2, then 3 for 8 cycles, then 0.
- Bounce: Boton toggles 1,0,1,0 every cycle for 6 cycles, then settles at 0 -> IN stays 0 and Estado_Salida stays 0 throughout.
- Queued press: second clean press released and repressed during COOLDOWN -> after 8 cooldown cycles the state goes to PENDING directly and IN=1. After a second ack, Peticiones=2.
- Held acknowledge: Pasar_Persona high 3 cycles -> SERVING held 3 cycles, Peticiones incremented only once, COOLDOWN entered on the edge after it falls.
- Saturation: 256 request/ack cycles -> Peticiones=255, no wrap.
